// File: rtl/lift_pkg.sv
// Shared definitions for the 4-floor lift: request codes understood by the
// lift FSM, travel direction, floor type, hall-call indices and their floors.
package lift_pkg;

  typedef logic [1:0] floor_t;
  typedef logic [2:0] call_idx_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam int NUM_CALLS = 6;

  // Pending-register index order: up calls first, then down calls
  localparam call_idx_t IDX_1U = 3'd0;
  localparam call_idx_t IDX_2U = 3'd1;
  localparam call_idx_t IDX_3U = 3'd2;
  localparam call_idx_t IDX_2D = 3'd3;
  localparam call_idx_t IDX_3D = 3'd4;
  localparam call_idx_t IDX_4D = 3'd5;

  // Lift FSM din encoding
  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_1U   = 3'b001;
  localparam logic [2:0] REQ_2U   = 3'b010;
  localparam logic [2:0] REQ_3U   = 3'b011;
  localparam logic [2:0] REQ_2D   = 3'b110;
  localparam logic [2:0] REQ_3D   = 3'b111;
  localparam logic [2:0] REQ_4D   = 3'b100;

  function automatic floor_t call_floor(input call_idx_t idx);
    case (idx)
      IDX_1U:         return 2'd0;
      IDX_2U, IDX_2D: return 2'd1;
      IDX_3U, IDX_3D: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  function automatic logic call_is_up(input call_idx_t idx);
    return idx <= IDX_3U;
  endfunction

  function automatic logic [2:0] call_code(input call_idx_t idx);
    case (idx)
      IDX_1U:  return REQ_1U;
      IDX_2U:  return REQ_2U;
      IDX_3U:  return REQ_3U;
      IDX_2D:  return REQ_2D;
      IDX_3D:  return REQ_3D;
      IDX_4D:  return REQ_4D;
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lift_call_picker.sv
// Combinational SCAN selector: keeps travelling in the current direction while
// calls lie ahead (or at) the car, otherwise reverses. Ties at one floor go to
// the call matching the pass: up call on the forward pass, down call on the
// reverse pass.
module lift_call_picker
  import lift_pkg::*;
(
  input  logic [5:0] pend,
  input  floor_t     cur_floor,
  input  dir_t       dir,
  output logic       pick_valid,
  output call_idx_t  pick_idx,
  output logic [2:0] pick_code,
  output dir_t       new_dir
);

  logic [5:0] at_or_above;
  logic [5:0] at_or_below;

  // Lowest floor wins; tie bit is 0 for the favoured call type
  function automatic call_idx_t search_low(input logic [5:0] m, input logic up_wins);
    call_idx_t  best;
    logic [2:0] best_key;
    logic [2:0] key;
    logic       hit;
    best     = IDX_1U;
    best_key = '1;
    hit      = 1'b0;
    for (int i = 0; i < NUM_CALLS; i++) begin
      key = {call_floor(call_idx_t'(i)), up_wins ^ call_is_up(call_idx_t'(i))};
      if (m[i] && (!hit || key < best_key)) begin
        best     = call_idx_t'(i);
        best_key = key;
        hit      = 1'b1;
      end
    end
    return best;
  endfunction

  // Highest floor wins; tie bit is 1 for the favoured call type
  function automatic call_idx_t search_high(input logic [5:0] m, input logic up_wins);
    call_idx_t  best;
    logic [2:0] best_key;
    logic [2:0] key;
    logic       hit;
    best     = IDX_1U;
    best_key = '0;
    hit      = 1'b0;
    for (int i = 0; i < NUM_CALLS; i++) begin
      key = {call_floor(call_idx_t'(i)), ~(up_wins ^ call_is_up(call_idx_t'(i)))};
      if (m[i] && (!hit || key > best_key)) begin
        best     = call_idx_t'(i);
        best_key = key;
        hit      = 1'b1;
      end
    end
    return best;
  endfunction

  // Split pending calls by position relative to the car
  always_comb begin
    at_or_above = '0;
    at_or_below = '0;
    for (int i = 0; i < NUM_CALLS; i++) begin
      at_or_above[i] = pend[i] && (call_floor(call_idx_t'(i)) >= cur_floor);
      at_or_below[i] = pend[i] && (call_floor(call_idx_t'(i)) <= cur_floor);
    end
  end

  // Forward pass in the current direction, else reverse
  always_comb begin
    pick_valid = |pend;
    pick_idx   = IDX_1U;
    new_dir    = dir;
    if (dir == DIR_UP) begin
      if (|at_or_above) begin
        pick_idx = search_low(at_or_above, 1'b1);
        new_dir  = DIR_UP;
      end else if (|at_or_below) begin
        pick_idx = search_high(at_or_below, 1'b0);
        new_dir  = DIR_DOWN;
      end
    end else begin
      if (|at_or_below) begin
        pick_idx = search_high(at_or_below, 1'b1);
        new_dir  = DIR_DOWN;
      end else if (|at_or_above) begin
        pick_idx = search_low(at_or_above, 1'b0);
        new_dir  = DIR_UP;
      end
    end
  end

  assign pick_code = call_code(pick_idx);

endmodule

// File: rtl/lift_call_scheduler.sv
// Hall-call scheduler: latches hall buttons, serves them one at a time to the
// lift FSM in SCAN order over its din/qEmpty interface.
// Build option LIFT_SCHED_WATCHDOG_EN adds a WAIT_DONE watchdog and the sticky
// fault output; without it WAIT_DONE waits for the lift indefinitely.
module lift_call_scheduler
  import lift_pkg::*;
`ifdef LIFT_SCHED_WATCHDOG_EN
#(
  parameter int unsigned WDOG_CYCLES = 64
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] up_call,
  input  logic [2:0] dn_call,
  input  floor_t     cur_floor,
  input  logic       lift_done,
  output logic [2:0] req_code,
  output logic       q_empty,
  output logic [5:0] call_lamp,
  output logic       busy
`ifdef LIFT_SCHED_WATCHDOG_EN
  ,
  output logic       fault
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_ISSUE, ST_SETTLE, ST_WAIT_DONE
  } state_t;

  state_t     state;
  dir_t       dir;
  logic [5:0] pend;
  logic [5:0] inflight_mask;
  logic       pick_valid;
  call_idx_t  pick_idx;
  logic [2:0] pick_code;
  dir_t       new_dir;
  logic       take;
  logic [5:0] pick_mask;
  logic [5:0] clr_mask;
  logic [5:0] absorb_mask;
  logic       hold_off;

  lift_call_picker u_picker (
    .pend       (pend),
    .cur_floor  (cur_floor),
    .dir        (dir),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx),
    .pick_code  (pick_code),
    .new_dir    (new_dir)
  );

  assign take        = (state == ST_SELECT) && pick_valid;
  assign pick_mask   = 6'b000001 << pick_idx;
  assign clr_mask    = take ? pick_mask : 6'b000000;
  // A press of the call being taken, or already in flight, is swallowed
  assign absorb_mask = inflight_mask | clr_mask;
  assign call_lamp   = pend | inflight_mask;

`ifdef LIFT_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  assign hold_off = fault;
`else
  assign hold_off = 1'b0;
`endif

  // Pending calls: new presses set, the taken call clears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | ({dn_call, up_call} & ~absorb_mask);
    end
  end

  // Request sequencer; req_code doubles as the registered selected code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dir           <= DIR_UP;
      inflight_mask <= '0;
      q_empty       <= 1'b1;
      req_code      <= REQ_NONE;
      busy          <= 1'b0;
`ifdef LIFT_SCHED_WATCHDOG_EN
      wdog_cnt      <= '0;
      fault         <= 1'b0;
`endif
    end else begin
      q_empty  <= 1'b1;
      req_code <= REQ_NONE;
      case (state)
        ST_IDLE: begin
          if ((pend != 6'b000000) && lift_done && !hold_off) begin
            state <= ST_SELECT;
            busy  <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (pick_valid) begin
            inflight_mask <= pick_mask;
            dir           <= new_dir;
            q_empty       <= 1'b0;
            req_code      <= pick_code;
            state         <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state <= ST_WAIT_DONE;
`ifdef LIFT_SCHED_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
        end
        ST_WAIT_DONE: begin
          if (lift_done) begin
            inflight_mask <= '0;
            state         <= ST_IDLE;
            busy          <= 1'b0;
`ifdef LIFT_SCHED_WATCHDOG_EN
          end else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            fault         <= 1'b1;
            inflight_mask <= '0;
            state         <= ST_IDLE;
            busy          <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with a behavioural SCAN model
// compared against the DUT on every falling edge.
module tb_lift_call_scheduler;

  localparam int WDOG = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] up_call = 3'b000;
  logic [2:0] dn_call = 3'b000;
  logic [1:0] cur_floor = 2'd0;
  logic       lift_done = 1'b1;
  logic [2:0] req_code;
  logic       q_empty;
  logic [5:0] call_lamp;
  logic       busy;
`ifdef LIFT_SCHED_WATCHDOG_EN
  logic       fault;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lift_call_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_call   (up_call),
    .dn_call   (dn_call),
    .cur_floor (cur_floor),
    .lift_done (lift_done),
    .req_code  (req_code),
    .q_empty   (q_empty),
    .call_lamp (call_lamp),
    .busy      (busy)
`ifdef LIFT_SCHED_WATCHDOG_EN
    ,
    .fault     (fault)
`endif
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 choosing, 2 request on the bus, 3 settling, 4 waiting for lift
  bit [5:0] m_pend;
  int       m_infl;
  bit       m_dn;
  int       m_ph;
  int       m_wait;
  bit       m_fault;
  bit       m_valid = 1'b0;

  function automatic logic [2:0] code_of(input int idx);
    case (idx)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b011;
      3: return 3'b110;
      4: return 3'b111;
      5: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] floor_of_code(input logic [2:0] c);
    case (c)
      3'b010, 3'b110: return 2'd1;
      3'b011, 3'b111: return 2'd2;
      3'b100:         return 2'd3;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic int up_at(input int f);
    return (f <= 2) ? f : -1;
  endfunction

  function automatic int dn_at(input int f);
    return (f >= 1) ? f + 2 : -1;
  endfunction

  // Walk floors outward from the car in travel direction, then back
  function automatic int model_pick(input bit [5:0] p, input int cur, input bit dn, output bit nd);
    nd = dn;
    if (!dn) begin
      for (int f = cur; f <= 3; f++) begin
        if (up_at(f) >= 0 && p[up_at(f)]) begin nd = 1'b0; return up_at(f); end
        if (dn_at(f) >= 0 && p[dn_at(f)]) begin nd = 1'b0; return dn_at(f); end
      end
      for (int f = cur; f >= 0; f--) begin
        if (dn_at(f) >= 0 && p[dn_at(f)]) begin nd = 1'b1; return dn_at(f); end
        if (up_at(f) >= 0 && p[up_at(f)]) begin nd = 1'b1; return up_at(f); end
      end
    end else begin
      for (int f = cur; f >= 0; f--) begin
        if (up_at(f) >= 0 && p[up_at(f)]) begin nd = 1'b1; return up_at(f); end
        if (dn_at(f) >= 0 && p[dn_at(f)]) begin nd = 1'b1; return dn_at(f); end
      end
      for (int f = cur; f <= 3; f++) begin
        if (dn_at(f) >= 0 && p[dn_at(f)]) begin nd = 1'b0; return dn_at(f); end
        if (up_at(f) >= 0 && p[up_at(f)]) begin nd = 1'b0; return up_at(f); end
      end
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [5:0] presses;
    bit [5:0] absorb;
    int       pk;
    bit       nd;
    presses = {dn_call, up_call};
    if (!rst_n) begin
      m_pend = '0; m_infl = -1; m_dn = 1'b0; m_ph = 0; m_wait = 0; m_fault = 1'b0;
      return;
    end
    absorb = (m_infl >= 0) ? 6'(1 << m_infl) : 6'b0;
    case (m_ph)
      0: if (m_pend != 0 && lift_done && !m_fault) m_ph = 1;
      1: begin
        pk = model_pick(m_pend, int'(cur_floor), m_dn, nd);
        if (pk >= 0) begin
          m_pend[pk] = 1'b0;
          m_infl = pk;
          m_dn = nd;
          absorb = absorb | 6'(1 << pk);
          m_ph = 2;
        end else m_ph = 0;
      end
      2: m_ph = 3;
      3: begin m_ph = 4; m_wait = 0; end
      4: begin
        if (lift_done) begin
          m_infl = -1; m_ph = 0;
        end else begin
          m_wait++;
`ifdef LIFT_SCHED_WATCHDOG_EN
          if (m_wait == WDOG) begin m_fault = 1'b1; m_infl = -1; m_ph = 0; end
`endif
        end
      end
      default: m_ph = 0;
    endcase
    m_pend = m_pend | (presses & ~absorb);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    m_valid = 1'b1;
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_q_empty", 8'(q_empty), 8'(m_ph != 2));
      check("model_req_code", 8'(req_code), 8'((m_ph == 2) ? code_of(m_infl) : 3'b000));
      check("model_busy", 8'(busy), 8'(m_ph != 0));
      check("model_call_lamp", 8'(call_lamp),
            8'(m_pend | ((m_infl >= 0) ? 6'(1 << m_infl) : 6'b0)));
`ifdef LIFT_SCHED_WATCHDOG_EN
      check("model_fault", 8'(fault), 8'(m_fault));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_issue(output logic [2:0] code);
    bit seen;
    seen = 1'b0;
    code = 3'b000;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (q_empty === 1'b0) begin
        seen = 1'b1;
        code = req_code;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL issue_wait: no request seen within 30 cycles, want one");
    end
  endtask

  // Take one request, keep the lift busy for 'hold' cycles, optionally re-press
  task automatic serve(input int hold, input logic [2:0] repress, output logic [2:0] code);
    wait_issue(code);
    lift_done = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      up_call = (i == 1) ? repress : 3'b000;
    end
    up_call = 3'b000;
    cur_floor = floor_of_code(code);
    lift_done = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] c;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_q_empty", 8'(q_empty), 8'h01);
      check("idle_req_code", 8'(req_code), 8'h00);
      check("idle_busy", 8'(busy), 8'h00);
    end
    check("idle_lamp", 8'(call_lamp), 8'h00);

    // Single 2U call from floor 1
    up_call = 3'b010;
    @(negedge clk);
    up_call = 3'b000;
    check("t2_lamp_set", 8'(call_lamp), 8'h02);
    @(negedge clk);
    check("t2_select_busy", 8'(busy), 8'h01);
    check("t2_select_q_empty", 8'(q_empty), 8'h01);
    @(negedge clk);
    check("t2_issue_q_empty", 8'(q_empty), 8'h00);
    check("t2_issue_code", 8'(req_code), 8'h02);
    lift_done = 1'b0;
    @(negedge clk);
    check("t2_issue_one_cycle", 8'(q_empty), 8'h01);
    repeat (2) @(negedge clk);
    check("t2_lamp_inflight", 8'(call_lamp), 8'h02);
    cur_floor = 2'd1;
    lift_done = 1'b1;
    @(negedge clk);
    check("t2_lamp_cleared", 8'(call_lamp), 8'h00);
    check("t2_back_idle", 8'(busy), 8'h00);

    // SCAN from floor 2 going up with 1U, 3U, 4D pending
    up_call = 3'b101;
    dn_call = 3'b100;
    @(negedge clk);
    up_call = 3'b000;
    dn_call = 3'b000;
    check("t3_lamp", 8'(call_lamp), 8'h25);
    serve(4, 3'b000, c); check("t3_first", 8'(c), 8'h03);
    serve(4, 3'b000, c); check("t3_second", 8'(c), 8'h04);
    serve(4, 3'b000, c); check("t3_third", 8'(c), 8'h01);

    // Heading down at floor 3 with 3U and 3D; 3U re-pressed while in flight
    cur_floor = 2'd2;
    up_call = 3'b100;
    dn_call = 3'b010;
    @(negedge clk);
    up_call = 3'b000;
    dn_call = 3'b000;
    serve(4, 3'b100, c); check("t4_first", 8'(c), 8'h03);
    check("t4_repress_absorbed", 8'(call_lamp), 8'h10);
    serve(4, 3'b000, c); check("t4_second", 8'(c), 8'h07);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_no_reissue", 8'(q_empty), 8'h01);
    end
    check("t4_lamp_empty", 8'(call_lamp), 8'h00);

    // Reset while waiting for the lift with three calls still pending
    up_call = 3'b011;
    dn_call = 3'b101;
    @(negedge clk);
    up_call = 3'b000;
    dn_call = 3'b000;
    wait_issue(c); check("t5_issue", 8'(c), 8'h02);
    lift_done = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_lamp_before_reset", 8'(call_lamp), 8'h2B);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_lamp", 8'(call_lamp), 8'h00);
    check("t5_rst_q_empty", 8'(q_empty), 8'h01);
    check("t5_rst_req_code", 8'(req_code), 8'h00);
    check("t5_rst_busy", 8'(busy), 8'h00);
    rst_n = 1'b1;
    lift_done = 1'b1;
    cur_floor = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_post_rst_idle", 8'(busy), 8'h00);
    end
    // Direction back to UP after reset: 3U before 1U from floor 2
    up_call = 3'b101;
    @(negedge clk);
    up_call = 3'b000;
    serve(4, 3'b000, c); check("t5_dir_up_first", 8'(c), 8'h03);
    serve(4, 3'b000, c); check("t5_dir_up_second", 8'(c), 8'h01);

`ifdef LIFT_SCHED_WATCHDOG_EN
    // Lift never reports done: watchdog trips and blocks further requests
    up_call = 3'b010;
    @(negedge clk);
    up_call = 3'b000;
    wait_issue(c); check("t6_issue", 8'(c), 8'h02);
    lift_done = 1'b0;
    repeat (65) @(negedge clk);
    check("t6_fault_not_yet", 8'(fault), 8'h00);
    @(negedge clk);
    check("t6_fault_set", 8'(fault), 8'h01);
    check("t6_idle_after_fault", 8'(busy), 8'h00);
    dn_call = 3'b001;
    lift_done = 1'b1;
    @(negedge clk);
    dn_call = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_no_issue_after_fault", 8'(q_empty), 8'h01);
    end
    check("t6_call_still_latched", 8'(call_lamp), 8'h08);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_fault_cleared", 8'(fault), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
